// File: rtl/rv32m_mul_issue_if.sv
// rtl/rv32m_mul_issue_if.sv - core request/response and multiplier control bundle for rv32m_mul_issue
interface rv32m_mul_issue_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;
  logic        resp_err_o;
  logic        mul_clr_o;
  logic        mul_en_o;
  logic [31:0] mul_op_a_o;
  logic [31:0] mul_op_b_o;
  logic        mul_signed_a_o;
  logic        mul_signed_b_o;
  logic        mul_upper_o;
  logic [31:0] mul_result_i;
  logic        mul_done_i;

  modport slave (
    input  req_valid_i, opcode_i, funct3_i, funct7_i, rs1_i, rs2_i, rd_i,
           resp_ready_i, mul_result_i, mul_done_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, resp_err_o,
           mul_clr_o, mul_en_o, mul_op_a_o, mul_op_b_o,
           mul_signed_a_o, mul_signed_b_o, mul_upper_o
  );

  modport master (
    output req_valid_i, opcode_i, funct3_i, funct7_i, rs1_i, rs2_i, rd_i,
           resp_ready_i, mul_result_i, mul_done_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, resp_err_o,
           mul_clr_o, mul_en_o, mul_op_a_o, mul_op_b_o,
           mul_signed_a_o, mul_signed_b_o, mul_upper_o
  );
endinterface

// File: rtl/rv32m_mul_issue.sv
// rtl/rv32m_mul_issue.sv - RV32M multiply issue/sequencing stage in front of a multi-cycle multiplier
module rv32m_mul_issue #(
  parameter int MUL_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rv32m_mul_issue_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_WAIT, S_RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               legal;
  logic               timeout;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        op_a;
  logic [31:0]        op_b;
  logic [4:0]         rd_q;
  logic               sgn_a;
  logic               sgn_b;
  logic               upper;
  logic [31:0]        data_q;
  logic               err_q;

  assign legal   = (bus.opcode_i == 7'b0110011) && (bus.funct7_i == 7'b0000001) && !bus.funct3_i[2];
  assign timeout = (cnt == CNT_W'(MUL_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.req_ready_o    = 1'b0;
    bus.resp_valid_o   = 1'b0;
    bus.mul_clr_o      = 1'b0;
    bus.mul_en_o       = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_nxt = legal ? S_CLR : S_RESP;
      end
      S_CLR: begin
        bus.mul_clr_o = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        bus.mul_en_o = 1'b1;
        if (bus.mul_done_i || timeout) state_nxt = S_RESP;
      end
      default: begin
        bus.resp_valid_o = 1'b1;
        if (bus.resp_ready_i) state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand/control registers only change on acceptance, so the multiplier
  // sees stable inputs for the whole WAIT phase and afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      rd_q   <= '0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      upper  <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            op_a   <= bus.rs1_i;
            op_b   <= bus.rs2_i;
            rd_q   <= bus.rd_i;
            sgn_a  <= ~(bus.funct3_i[1] & bus.funct3_i[0]);
            sgn_b  <= ~bus.funct3_i[1];
            upper  <= bus.funct3_i[1] | bus.funct3_i[0];
            data_q <= '0;
            err_q  <= ~legal;
          end
        end
        S_CLR: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // done takes priority over the timeout limit in the same cycle
          if (bus.mul_done_i) begin
            data_q <= bus.mul_result_i;
            err_q  <= 1'b0;
          end else if (timeout) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_data_o    = data_q;
  assign bus.resp_rd_o      = rd_q;
  assign bus.resp_err_o     = err_q;
  assign bus.mul_op_a_o     = op_a;
  assign bus.mul_op_b_o     = op_b;
  assign bus.mul_signed_a_o = sgn_a;
  assign bus.mul_signed_b_o = sgn_b;
  assign bus.mul_upper_o    = upper;

endmodule

// File: tb/tb_rv32m_mul_issue.sv
// tb/tb_rv32m_mul_issue.sv - scoreboard bench for rv32m_mul_issue with a behavioural multiplier
module tb_rv32m_mul_issue;
  localparam int TO = 15;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32m_mul_issue_if bus();

  rv32m_mul_issue #(.MUL_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  resp_t       exp_q[$];
  int          n_vec   = 0;
  int          n_err   = 0;
  int          clr_cnt = 0;
  int          en_cnt  = 0;
  int          mcyc    = 0;
  int          mlat    = 7;
  logic [2:0]  exp_ctl = 3'b000;
  logic [31:0] exp_a   = '0;
  logic [31:0] exp_b   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural result of an RV32M multiply, straight from the ISA definition
  function automatic logic [31:0] ref_resp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned ua, ubu, pu;
    logic [31:0]     lo;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ua  = {32'b0, a};
    ubu = {32'b0, b};
    lo  = a * b;
    case (f3[1:0])
      2'd0: return lo;
      2'd1: begin p = sa * sb; return p[63:32]; end
      2'd2: begin p = sa * ub; return p[63:32]; end
      default: begin pu = ua * ubu; return pu[63:32]; end
    endcase
  endfunction

  function automatic logic [2:0] ctl_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0: return 3'b110;
      2'd1: return 3'b111;
      2'd2: return 3'b101;
      default: return 3'b001;
    endcase
  endfunction

  // Multiplier stand-in: driven by the DUT's controls, done after mlat enabled cycles
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic up);
    logic signed [65:0] ea, eb, p;
    ea = sa ? $signed({{34{a[31]}}, a}) : $signed({34'b0, a});
    eb = sb ? $signed({{34{b[31]}}, b}) : $signed({34'b0, b});
    p  = ea * eb;
    return up ? p[63:32] : p[31:0];
  endfunction

  always @(posedge clk) begin
    if (bus.mul_clr_o)     mcyc <= 0;
    else if (bus.mul_en_o) mcyc <= mcyc + 1;
  end

  assign bus.mul_done_i   = bus.mul_en_o && (mcyc == mlat - 1);
  assign bus.mul_result_i = mul_model(bus.mul_op_a_o, bus.mul_op_b_o,
                                      bus.mul_signed_a_o, bus.mul_signed_b_o, bus.mul_upper_o);

  initial begin : monitor
    logic  held;
    resp_t hv;
    resp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (bus.mul_clr_o) clr_cnt++;
        if (bus.mul_en_o) begin
          en_cnt++;
          chk("wait_ctl", {29'b0, bus.mul_signed_a_o, bus.mul_signed_b_o, bus.mul_upper_o}, {29'b0, exp_ctl});
          chk("wait_op_a", bus.mul_op_a_o, exp_a);
          chk("wait_op_b", bus.mul_op_b_o, exp_b);
        end
        if (held) begin
          chk("stall_valid", {31'b0, bus.resp_valid_o}, 32'd1);
          chk("stall_data", bus.resp_data_o, hv.data);
          chk("stall_rd", {27'b0, bus.resp_rd_o}, {27'b0, hv.rd});
          chk("stall_err", {31'b0, bus.resp_err_o}, {31'b0, hv.err});
        end
        if (bus.resp_valid_o) chk("resp_req_ready", {31'b0, bus.req_ready_o}, 32'd0);
        held = bus.resp_valid_o && !bus.resp_ready_i;
        hv   = '{bus.resp_data_o, bus.resp_rd_o, bus.resp_err_o};
        if (bus.resp_valid_o && bus.resp_ready_i) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp: got data 0x%08h rd %0d with nothing outstanding", bus.resp_data_o, bus.resp_rd_o);
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", bus.resp_data_o, e.data);
            chk("resp_rd", {27'b0, bus.resp_rd_o}, {27'b0, e.rd});
            chk("resp_err", {31'b0, bus.resp_err_o}, {31'b0, e.err});
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_op(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int lat, input int stall);
    bit    legal;
    resp_t e;
    int    exp_lat, n, c0, e0;
    legal = (opc == 7'b0110011) && (f7 == 7'b0000001) && !f3[2];
    if (!legal) begin
      e = '{32'h0, rd, 1'b1};           exp_lat = 1;
    end else if (lat <= TO) begin
      e = '{ref_resp(f3, a, b), rd, 1'b0}; exp_lat = 2 + lat;
    end else begin
      e = '{32'h0, rd, 1'b1};           exp_lat = 2 + TO;
    end
    step();
    chk("idle_ready", {31'b0, bus.req_ready_o}, 32'd1);
    bus.opcode_i = opc; bus.funct7_i = f7; bus.funct3_i = f3;
    bus.rs1_i = a; bus.rs2_i = b; bus.rd_i = rd;
    bus.req_valid_i  = 1'b1;
    bus.resp_ready_i = (stall == 0);
    mlat = lat; exp_ctl = ctl_of(f3); exp_a = a; exp_b = b;
    exp_q.push_back(e);
    c0 = clr_cnt; e0 = en_cnt;
    step();
    bus.req_valid_i = 1'b0;
    n = 1;
    while (!bus.resp_valid_o && n < 40) begin
      step();
      n++;
    end
    chk("resp_latency", n, exp_lat);
    if (stall > 0) begin
      bus.req_valid_i = 1'b1;
      bus.rs1_i = $urandom; bus.rd_i = 5'(rd + 1);
      for (int s = 0; s < stall; s++) begin
        step();
        chk("stall_req_ready", {31'b0, bus.req_ready_o}, 32'd0);
      end
      bus.req_valid_i  = 1'b0;
      bus.resp_ready_i = 1'b1;
    end
    step();
    chk("post_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    chk("post_ready", {31'b0, bus.req_ready_o}, 32'd1);
    chk("clr_pulses", clr_cnt - c0, legal ? 1 : 0);
    chk("en_cycles", en_cnt - e0, legal ? ((lat < TO) ? lat : TO) : 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, bus.req_ready_o}, 32'd1);
    chk({tag, "_resp_valid"}, {31'b0, bus.resp_valid_o}, 32'd0);
    chk({tag, "_mul_clr"}, {31'b0, bus.mul_clr_o}, 32'd0);
    chk({tag, "_mul_en"}, {31'b0, bus.mul_en_o}, 32'd0);
    chk({tag, "_resp_data"}, bus.resp_data_o, 32'd0);
    chk({tag, "_resp_rd"}, {27'b0, bus.resp_rd_o}, 32'd0);
    chk({tag, "_resp_err"}, {31'b0, bus.resp_err_o}, 32'd0);
    chk({tag, "_op_a"}, bus.mul_op_a_o, 32'd0);
    chk({tag, "_op_b"}, bus.mul_op_b_o, 32'd0);
    chk({tag, "_ctl"}, {29'b0, bus.mul_signed_a_o, bus.mul_signed_b_o, bus.mul_upper_o}, 32'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] pool [5];
    logic [2:0]  f3;
    logic [6:0]  opc, f7;
    int          kind;
    bus.req_valid_i = 1'b0; bus.resp_ready_i = 1'b1;
    bus.opcode_i = '0; bus.funct3_i = '0; bus.funct7_i = '0;
    bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;
    rst = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;

    run_op(7'h33, 7'h01, 3'd0, 32'h80000001, 32'h80010002, 5'd5, 7, 0);
    run_op(7'h33, 7'h01, 3'd1, 32'h80000001, 32'h80010002, 5'd6, 7, 0);
    run_op(7'h33, 7'h01, 3'd2, 32'h80000001, 32'h80010002, 5'd7, 7, 0);
    run_op(7'h33, 7'h01, 3'd3, 32'h80000001, 32'h80010002, 5'd8, 7, 0);
    run_op(7'h33, 7'h01, 3'd4, 32'h12345678, 32'h00000003, 5'd9, 7, 0);
    run_op(7'h13, 7'h01, 3'd0, 32'h12345678, 32'h00000003, 5'd10, 7, 0);
    run_op(7'h33, 7'h01, 3'd0, 32'hDEADBEEF, 32'h00000011, 5'd11, 100, 0);
    run_op(7'h33, 7'h01, 3'd0, 32'h00000007, 32'h00000006, 5'd12, 7, 0);
    run_op(7'h33, 7'h01, 3'd1, 32'hFFFFFFFF, 32'h7FFFFFFF, 5'd13, TO, 0);
    run_op(7'h33, 7'h01, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 1, 0);
    run_op(7'h33, 7'h01, 3'd2, 32'hCAFEF00D, 32'h87654321, 5'd15, 4, 5);

    // reset while the multiplier is busy: the transaction must vanish
    step();
    bus.opcode_i = 7'h33; bus.funct7_i = 7'h01; bus.funct3_i = 3'd0;
    bus.rs1_i = 32'h0BADF00D; bus.rs2_i = 32'h00000005; bus.rd_i = 5'd21;
    bus.req_valid_i = 1'b1; mlat = 20; exp_ctl = ctl_of(3'd0); exp_a = 32'h0BADF00D; exp_b = 32'h5;
    step();
    bus.req_valid_i = 1'b0;
    repeat (3) step();
    chk("pre_reset_in_wait", {31'b0, bus.mul_en_o}, 32'd1);
    rst = 1'b1;
    step();
    check_idle_outputs("midreset");
    rst = 1'b0;
    run_op(7'h33, 7'h01, 3'd0, 32'h00010001, 32'h00010001, 5'd22, 7, 0);

    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFFFFFF; pool[3] = 32'h80000000; pool[4] = 32'h7FFFFFFF;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      opc = 7'h33; f7 = 7'h01; f3 = 3'($urandom_range(0, 3));
      if (kind == 0) f3 = 3'($urandom_range(4, 7));
      if (kind == 1) opc = 7'h13;
      if (kind == 2) f7 = 7'h20;
      run_op(opc, f7, f3,
             ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : 32'($urandom),
             ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : 32'($urandom),
             5'($urandom), $urandom_range(1, 16), $urandom_range(0, 3));
    end

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rv32m_mul_issue.md
Name: rv32m_mul_issue

Overview:
- Issue/sequencing stage directly upstream of multiplier_top_V2.
- Accepts an R-type instruction plus rs1/rs2 from the core over a valid/ready handshake and decodes MUL/MULH/MULHSU/MULHU.
- Clears the multiplier, holds operands and controls stable until done_o, then returns the 32-bit result and rd to the core over a second valid/ready handshake.
- Rejects non-multiply encodings and flags a multiplier timeout.

Parameters:
- MUL_TIMEOUT, 15: max WAIT cycles without mul_done_i before an error response.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MUL_TIMEOUT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  core offers an instruction.
- req_ready_o  out  1  block can accept (IDLE only).
- opcode_i  in  7  instruction opcode.
- funct3_i  in  3  instruction funct3.
- funct7_i  in  7  instruction funct7.
- rs1_i  in  32  operand A.
- rs2_i  in  32  operand B.
- rd_i  in  5  destination register tag.
- resp_valid_o  out  1  response available.
- resp_ready_i  in  1  core takes the response.
- resp_data_o  out  32  multiplier result, or 0 on error.
- resp_rd_o  out  5  rd of the answered request.
- resp_err_o  out  1  1 = illegal encoding or timeout.
- mul_clr_o  out  1  drives multiplier rst_i.
- mul_en_o  out  1  drives mult_en_i.
- mul_op_a_o  out  32  drives op_A_i.
- mul_op_b_o  out  32  drives op_B_i.
- mul_signed_a_o  out  1  drives signed_A_i.
- mul_signed_b_o  out  1  drives signed_B_i.
- mul_upper_o  out  1  drives upper_i.
- mul_result_i  in  32  from result_o.
- mul_done_i  in  1  from done_o.

Behaviour:
- Reset (synchronous, active-high; also mid-operation): state=IDLE; all outputs 0 except req_ready_o=1; counter=0; operand, rd and result registers=0. A reset during WAIT or RESP drops the transaction and no response is produced.
- Decode: legal iff opcode=0110011, funct7=0000001, funct3[2]=0.
  - 000 MUL: sA=1, sB=1, upper=0.
  - 001 MULH: 1, 1, 1.
  - 010 MULHSU: 1, 0, 1.
  - 011 MULHU: 0, 0, 1.
- FSM states: IDLE, CLR, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o at edge T: register rs1, rs2, rd, sA, sB, upper.
  - If legal, go to CLR. If illegal, go to RESP with err=1, data=0; the multiplier is not touched.
- CLR (cycle T+1): mul_clr_o=1, mul_en_o=0, counter cleared. Always go to WAIT.
- WAIT (from T+2):
  - mul_en_o=1, mul_clr_o=0; operands and controls come from registers and are stable for the whole op.
  - Counter increments each cycle.
  - If mul_done_i=1: capture mul_result_i, err=0, go to RESP.
  - Else if counter==MUL_TIMEOUT-1: data=0, err=1, go to RESP.
  - If done and the timeout limit occur in the same cycle, done wins.
- RESP:
  - resp_valid_o=1, data/rd/err held stable; mul_en_o=0.
  - On resp_ready_i, go to IDLE on the next edge.
  - req_ready_o=0, so there is no back-to-back overlap. Response valid/data must not change while stalled.
- mul_op_*/mul_signed_*/mul_upper_o retain their last values outside WAIT. Only mul_en_o and mul_clr_o gate the multiplier.
- Latency for a legal op: resp_valid_o rises at T+2+L, where L = number of WAIT cycles until mul_done_i, L ≥ 1.
- Throughput: one op per (3+L) cycles, given resp_ready_i=1.
- No arithmetic is done here; resp_data_o is a pass-through of mul_result_i.

Test Plan:
- MUL, rs1=0x80000001, rs2=0x80010002, rd=5, real multiplier (7 stages) → one-cycle mul_clr_o pulse; controls 1/1/0; resp_data_o=0x80010002, rd=5, err=0.
- MULH, MULHSU, MULHU with the same operands → 0x3FFF7FFE, 0xBFFF7FFF, 0x40008001 respectively; controls 1/1/1, 1/0/1, 0/0/1.
- DIV (funct3=100) and opcode 0010011 → no mul_clr_o/mul_en_o activity; response at T+1 with err=1, data=0.
- Stub multiplier that never raises done → resp at T+2+MUL_TIMEOUT with err=1, data=0; block then accepts the next MUL normally.
- resp_ready_i held low 5 cycles, with req_valid_i high throughout → req_ready_o=0 and data/rd stable all 5 cycles; the new request is accepted only after the handshake.
- rst_i asserted in WAIT cycle 3 → next cycle is IDLE, all outputs 0, req_ready_o=1, and no response is emitted.
